// File: rtl/fifo_pkg.sv
// Constants shared by the FIFO family: the default entry width and the pop-decision encoding.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 65;

  localparam logic [1:0] FIFO_POP_NONE = 2'd0;
  localparam logic [1:0] FIFO_POP_ONE  = 2'd1;
  localparam logic [1:0] FIFO_POP_TWO  = 2'd2;

endpackage

// File: rtl/fifo_occupancy_ctr.sv
// Occupancy counter for the 1-write/2-read FIFO. It keeps count, Full/Empty flags and the sticky overflow flag.
// The flags are decoded from the registered count, so every full/empty decision uses the state before this edge's update.
module fifo_occupancy_ctr
  import fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Clear_in,
  input  logic                     stall,
  input  logic                     push,
  input  logic [1:0]               pop_n,
  input  logic                     wr_req,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH_C = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] TWO_C   = (ADDRESS_WIDTH+1)'(2);

  logic [ADDRESS_WIDTH:0] push_amt;
  logic [ADDRESS_WIDTH:0] pop_amt;

  always_comb begin
    push_amt = {{ADDRESS_WIDTH{1'b0}}, push};
    pop_amt  = '0;
    if (pop_n == FIFO_POP_TWO) begin
      pop_amt = TWO_C;
    end else if (pop_n == FIFO_POP_ONE) begin
      pop_amt = (ADDRESS_WIDTH+1)'(1);
    end
  end

  assign full  = (count == DEPTH_C);
  assign empty = (count < TWO_C);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (Clear_in) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (!stall) begin
      count <= count + push_amt - pop_amt;
      // A write attempt against a full FIFO is dropped and recorded.
      if (wr_req && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_1w_2r.sv
// Single-clock FIFO: one entry in per cycle, and a pair of entries out per read. A single entry can come out in drain mode.
// Read data appears one cycle after the pop. The stall input freezes both sides, and a push into a full FIFO is dropped and flagged.
module fifo_1w_2r
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = 3,
  parameter int FIFO_DEPTH    = 1 << ADDRESS_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Clear_in,
  input  logic                     stall,
  input  logic [DATA_WIDTH-1:0]    Data_in,
  input  logic                     WriteEn_in,
  output logic                     Full_out,
  input  logic                     ReadEn_in,
  input  logic                     Drain_in,
  output logic [DATA_WIDTH-1:0]    Data_out_1,
  output logic [DATA_WIDTH-1:0]    Data_out_2,
  output logic                     Data_valid,
  output logic                     Data_valid_2,
  output logic                     Empty_out,
  output logic [ADDRESS_WIDTH:0]   Count_out,
  output logic                     Overflow_out
);

  localparam logic [ADDRESS_WIDTH:0]   DEPTH_C = (ADDRESS_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   TWO_C   = (ADDRESS_WIDTH+1)'(2);
  localparam logic [ADDRESS_WIDTH:0]   ONE_C   = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_1   = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_2   = ADDRESS_WIDTH'(2);

  (* ramstyle = "logic" *) logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_p1;
  logic [ADDRESS_WIDTH-1:0] ptr_diff;
  logic [ADDRESS_WIDTH:0]   count;
  logic                     push;
  logic [1:0]               pop_n;

  assign push      = WriteEn_in & ~stall & ~Full_out & ~Clear_in;
  assign rd_ptr_p1 = rd_ptr + PTR_1;
  assign ptr_diff  = wr_ptr - rd_ptr;
  assign Count_out = count;

  always_comb begin
    pop_n = FIFO_POP_NONE;
    if (!Clear_in && !stall && ReadEn_in) begin
      if (count >= TWO_C) begin
        pop_n = FIFO_POP_TWO;
      end else if (count == ONE_C && Drain_in) begin
        pop_n = FIFO_POP_ONE;
      end
    end
  end

  fifo_occupancy_ctr #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_occ (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Clear_in (Clear_in),
    .stall    (stall),
    .push     (push),
    .pop_n    (pop_n),
    .wr_req   (WriteEn_in),
    .count    (count),
    .full     (Full_out),
    .empty    (Empty_out),
    .overflow (Overflow_out)
  );

  // Memory contents survive reset and clear. Only the pointers define what is live.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= Data_in;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (Clear_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_1;
      end
      if (pop_n == FIFO_POP_TWO) begin
        rd_ptr <= rd_ptr + PTR_2;
      end else if (pop_n == FIFO_POP_ONE) begin
        rd_ptr <= rd_ptr_p1;
      end
    end
  end

  // Clear drops the valids but keeps the last read data on the outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Data_out_1   <= '0;
      Data_out_2   <= '0;
      Data_valid   <= 1'b0;
      Data_valid_2 <= 1'b0;
    end else begin
      Data_valid   <= (pop_n != FIFO_POP_NONE);
      Data_valid_2 <= (pop_n == FIFO_POP_TWO);
      if (pop_n != FIFO_POP_NONE) begin
        Data_out_1 <= mem[rd_ptr];
      end
      if (pop_n == FIFO_POP_TWO) begin
        Data_out_2 <= mem[rd_ptr_p1];
      end
    end
  end

  a_occupancy_consistent : assert property (@(posedge Clk) disable iff (!Reset_n)
    (count <= DEPTH_C) && (ptr_diff == count[ADDRESS_WIDTH-1:0]));

endmodule

// File: tb/tb_fifo_1w_2r.sv
// Randomised and directed stimulus for fifo_1w_2r. The expected results come from a queue-based reference model.
// The monitor checks every cycle's outputs against a scoreboard.
module tb_fifo_1w_2r;

  localparam int DW    = 65;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Clear_in = 1'b0;
  logic          stall = 1'b0;
  logic [DW-1:0] Data_in = '0;
  logic          WriteEn_in = 1'b0;
  logic          Full_out;
  logic          ReadEn_in = 1'b0;
  logic          Drain_in = 1'b0;
  logic [DW-1:0] Data_out_1;
  logic [DW-1:0] Data_out_2;
  logic          Data_valid;
  logic          Data_valid_2;
  logic          Empty_out;
  logic [AW:0]   Count_out;
  logic          Overflow_out;

  fifo_1w_2r #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Clear_in     (Clear_in),
    .stall        (stall),
    .Data_in      (Data_in),
    .WriteEn_in   (WriteEn_in),
    .Full_out     (Full_out),
    .ReadEn_in    (ReadEn_in),
    .Drain_in     (Drain_in),
    .Data_out_1   (Data_out_1),
    .Data_out_2   (Data_out_2),
    .Data_valid   (Data_valid),
    .Data_valid_2 (Data_valid_2),
    .Empty_out    (Empty_out),
    .Count_out    (Count_out),
    .Overflow_out (Overflow_out)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          v;
    logic          v2;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    int            cnt;
    logic          ovf;
  } rec_t;

  rec_t          exp_q[$];
  logic [DW-1:0] model_q[$];
  logic          m_ovf = 1'b0;
  logic [DW-1:0] m_d1 = '0;
  rec_t          pend;
  bit            have_pend = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Monitor: one scoreboard record describes the state after one clock edge.
  initial begin
    rec_t r;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("valid",    DW'(Data_valid),   DW'(r.v));
        chk("valid_2",  DW'(Data_valid_2), DW'(r.v2));
        chk("data_1",   Data_out_1,        r.d1);
        if (r.v2) chk("data_2", Data_out_2, r.d2);
        chk("count",    DW'(Count_out),    DW'(r.cnt));
        chk("full",     DW'(Full_out),     DW'(r.cnt == DEPTH));
        chk("empty",    DW'(Empty_out),    DW'(r.cnt < 2));
        chk("overflow", DW'(Overflow_out), DW'(r.ovf));
      end
    end
  end

  function automatic rec_t idle_rec();
    rec_t r;
    r.v = 1'b0; r.v2 = 1'b0; r.d1 = m_d1; r.d2 = '0;
    r.cnt = model_q.size(); r.ovf = m_ovf;
    return r;
  endfunction

  task automatic drive(input logic we, input logic [DW-1:0] din, input logic re,
                       input logic dr, input logic st, input logic clr);
    rec_t r;
    int   n;
    @(posedge Clk); #1;
    if (have_pend) exp_q.push_back(pend);
    WriteEn_in = we; Data_in = din; ReadEn_in = re;
    Drain_in = dr; stall = st; Clear_in = clr;
    r = idle_rec();
    if (clr) begin
      model_q.delete();
      m_ovf = 1'b0;
    end else if (!st) begin
      n = model_q.size();
      if (re && n >= 2) begin
        r.v = 1'b1; r.v2 = 1'b1;
        m_d1 = model_q.pop_front();
        r.d2 = model_q.pop_front();
      end else if (re && dr && n == 1) begin
        r.v = 1'b1;
        m_d1 = model_q.pop_front();
      end
      if (we) begin
        if (n == DEPTH) m_ovf = 1'b1;
        else model_q.push_back(din);
      end
    end
    r.d1 = m_d1; r.cnt = model_q.size(); r.ovf = m_ovf;
    pend = r;
    have_pend = 1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    WriteEn_in = 0; ReadEn_in = 0; Drain_in = 0; stall = 0; Clear_in = 0;
    model_q.delete(); m_ovf = 1'b0; m_d1 = '0;
    exp_q.push_back(idle_rec());
    for (int i = 1; i < cycles; i++) begin
      @(posedge Clk); #1;
      exp_q.push_back(idle_rec());
    end
    @(posedge Clk); #1;
    exp_q.push_back(idle_rec());
    Reset_n = 1'b1;
    pend = idle_rec();
    have_pend = 1;
  endtask

  task automatic push_v(input logic [DW-1:0] d);
    drive(1, d, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic dr);
    drive(0, '0, 1, dr, 0, 0);
  endtask

  function automatic logic [DW-1:0] rnd();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    // Pairs come out in order, then the FIFO reports empty.
    do_reset(2);
    for (int i = 1; i <= 4; i++) push_v(DW'(i));
    rd(0); rd(0);
    drive(0, '0, 0, 0, 0, 0);

    // Fill to full. The ninth write is dropped and overflow stays set.
    do_reset(1);
    for (int i = 0; i < 9; i++) push_v(DW'(16 + i));
    drive(0, '0, 0, 0, 0, 0); drive(0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) rd(0);

    // A single leftover entry comes out only in drain mode.
    do_reset(1);
    push_v(DW'('hA)); push_v(DW'('hB)); push_v(DW'('hC));
    rd(0); rd(0); rd(1);
    drive(0, '0, 0, 0, 0, 0);

    // Pair pop straddling the pointer wrap: rd_ptr = 7.
    do_reset(1);
    for (int i = 0; i < 7; i++) push_v(DW'(32 + i));
    rd(0); rd(0); rd(0); rd(1);
    push_v(DW'('h77)); push_v(DW'('h80));
    rd(0);
    drive(0, '0, 0, 0, 0, 0);

    // Streaming at count 4 with a read every other cycle, then the same with stall pulses.
    do_reset(1);
    for (int i = 0; i < 4; i++) push_v(rnd());
    for (int i = 0; i < 20; i++) drive(1, rnd(), 1'(i % 2), 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(1, rnd(), 1'(i % 2), 0, 1'(i % 5 == 2), 0);

    // Reset mid-stream, then clear while both write and read are requested.
    rd(0); push_v(rnd()); rd(0);
    do_reset(2);
    for (int i = 0; i < 9; i++) push_v(rnd());
    drive(1, rnd(), 1, 1, 0, 1);
    push_v(DW'('h5A)); push_v(DW'('h5B)); rd(0);
    drive(0, '0, 0, 0, 0, 0);

    // Random traffic with occasional stall, clear and reset.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset(1 + $urandom_range(0, 1));
      else drive(1'($urandom_range(0, 99) < 60), rnd(),
                 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 30),
                 1'($urandom_range(0, 99) < 10),
                 1'($urandom_range(0, 99) < 2));
    end
    drive(0, '0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    if (have_pend) exp_q.push_back(pend);
    have_pend = 0;
    @(posedge Clk); #7;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d records left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
